// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS constants, fetch FSM states and opcode encodings
package mips_pkg;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } fetch_state_e;

    // Primary opcodes seen by the Control unit on if_id_instr[31:26].
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - program counter flop with load enable and async active-low reset
module pc_register
    import mips_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [WIDTH-1:0] pc_d,
    output logic [WIDTH-1:0] pc_q
);

    // Load a new PC only when the fetch logic says the current one is done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (load_en) begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - MIPS fetch stage and IF/ID register; FETCH_PERF_CNT_EN enables perf counters
module instruction_fetch_stage
    import mips_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0] imem_addr,
    output logic                  imem_req,
    input  logic                  imem_ready,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
    output logic                  if_id_valid,
    output logic                  misalign,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
);

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  pc_load;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
    logic                  valid_q, valid_d;
    logic                  misalign_q, misalign_d;
    logic [DATA_WIDTH-1:0] pc_plus4;

    assign pc_plus4 = pc_q + DATA_WIDTH'(4);

    pc_register #(
        .WIDTH    (DATA_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk     (clk),
        .rst_n   (reset),
        .load_en (pc_load),
        .pc_d    (pc_d),
        .pc_q    (pc_q)
    );

    // Next-state: redirect beats stall, stall beats a missing word, else consume the word.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_load    = 1'b0;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        misalign_d = 1'b0;
        if (redirect_valid) begin
            pc_load    = 1'b1;
            pc_d       = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            instr_d    = DATA_WIDTH'(NOP_WORD);
            pc4_d      = '0;
            valid_d    = 1'b0;
            misalign_d = |redirect_pc[1:0];
            state_d    = ST_FETCH;
        end else if (state_q == ST_BOOT) begin
            state_d = ST_FETCH;
        end else if (stall) begin
            // Hold everything; any word returned now is dropped and re-fetched.
            state_d = state_q;
        end else if (!imem_ready) begin
            instr_d = DATA_WIDTH'(NOP_WORD);
            pc4_d   = '0;
            valid_d = 1'b0;
            state_d = ST_WAIT;
        end else begin
            pc_load = 1'b1;
            pc_d    = pc_plus4;
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            state_d = ST_FETCH;
        end
    end

    // FSM state, IF/ID pipeline register and misalign pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            instr_q    <= DATA_WIDTH'(NOP_WORD);
            pc4_q      <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Saturating performance counters for stalled and flushed cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && !redirect_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect_valid && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'h0;
    assign flush_cnt = 32'h0;
`endif

    assign imem_addr      = pc_q;
    assign imem_req       = (state_q != ST_BOOT);
    assign pc             = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;
    assign if_id_valid    = valid_q;
    assign misalign       = misalign_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - directed table-driven bench for instruction_fetch_stage
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        misalign;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instruction memory: word k (from 0x00400000) holds k+1.
    assign imem_rdata = ((imem_addr - 32'h0040_0000) >> 2) + 32'd1;

    instruction_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .misalign       (misalign),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
        logic        req;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},    pc, 32'h0040_0000);
        check({tag, "_addr"},  imem_addr, 32'h0040_0000);
        check({tag, "_instr"}, if_id_instr, 32'h0);
        check({tag, "_pc4"},   if_id_pc_plus4, 32'h0);
        check({tag, "_valid"}, {31'h0, if_id_valid}, 32'h0);
        check({tag, "_mis"},   {31'h0, misalign}, 32'h0);
        check({tag, "_req"},   {31'h0, imem_req}, 32'h0);
        check({tag, "_scnt"},  stall_cnt, 32'h0);
        check({tag, "_fcnt"},  flush_cnt, 32'h0);
    endtask

    initial begin
        //            stall rv  rpc           rdy  pc            instr         pc4           val mis req
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_0000, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_0004, 32'h1,        32'h0040_0004, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_0008, 32'h2,        32'h0040_0008, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0040_0008, 32'h2,        32'h0040_0008, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0040_0008, 32'h2,        32'h0040_0008, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0040_0008, 32'h2,        32'h0040_0008, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_000C, 32'h3,        32'h0040_000C, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0040_000C, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0040_000C, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_0010, 32'h4,        32'h0040_0010, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 32'h0040_1000, 1'b1, 32'h0040_1000, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_1004, 32'h401,      32'h0040_1004, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'h0040_0006, 1'b1, 32'h0040_0004, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_0008, 32'h2,        32'h0040_0008, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 32'h3FF0_0000, 32'h0,        1'b1, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 32'h3FF0_0001, 32'h4,        1'b1, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0004, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1};

        reset          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ready     = 1'b1;
        #12;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            stall          = vecs[i].stall;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            imem_ready     = vecs[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pc", i),    pc, vecs[i].pc);
            check($sformatf("v%0d_addr", i),  imem_addr, vecs[i].pc);
            check($sformatf("v%0d_instr", i), if_id_instr, vecs[i].instr);
            if (vecs[i].valid)
                check($sformatf("v%0d_pc4", i), if_id_pc_plus4, vecs[i].pc4);
            check($sformatf("v%0d_valid", i), {31'h0, if_id_valid}, {31'h0, vecs[i].valid});
            check($sformatf("v%0d_mis", i),   {31'h0, misalign}, {31'h0, vecs[i].mis});
            check($sformatf("v%0d_req", i),   {31'h0, imem_req}, {31'h0, vecs[i].req});
        end

`ifdef FETCH_PERF_CNT_EN
        check("stall_cnt", stall_cnt, 32'd3);
        check("flush_cnt", flush_cnt, 32'd3);
`else
        check("stall_cnt", stall_cnt, 32'd0);
        check("flush_cnt", flush_cnt, 32'd0);
`endif

        // DUT now waits on imem_ready; assert reset between clock edges.
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async");

        // Release again: one idle boot cycle, then the first word.
        imem_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("boot_valid", {31'h0, if_id_valid}, 32'h0);
        check("boot_pc", pc, 32'h0040_0000);
        @(posedge clk);
        #1;
        check("refetch_instr", if_id_instr, 32'h1);
        check("refetch_pc4", if_id_pc_plus4, 32'h0040_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
